// File: rtl/tx_audio_fifo_wb.sv
// Transmit audio sample FIFO: buffers ecpu samples and releases them at a programmed rate.
// Optional macro TX_TICKS_EN latches ticks_A at each PRIME->RUN transition onto tx_ticks_A.
module tx_audio_fifo_wb #(
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic                  adc_clk,
    input  logic                  rst_n,
    input  logic [31:0]           freeze_tos_A,
    input  logic                  wr_samp_A,
    input  logic                  set_nsamps_A,
    input  logic                  set_decim_A,
    input  logic                  start_A,
    input  logic                  flush_A,
    input  logic [47:0]           ticks_A,
    output logic [15:0]           tx_dout_A,
    output logic                  tx_strobe_A,
    output logic                  srq_A,
    output logic [DEPTH_LOG2:0]   count_A,
    output logic                  underrun_A,
    output logic                  overflow_A,
    output logic [47:0]           tx_ticks_A
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [15:0]            nsamps_q, nsamps_d;
    logic [15:0]            decim_q, decim_d;
    logic [15:0]            div_q, div_d;
    logic                   strobe_q, strobe_d;
    logic                   zero_q, zero_d;
    logic                   underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;

    logic [15:0]            mem_q [DEPTH];
    logic [15:0]            rd_q;

    logic                   full, empty, tick, wr_ok, pop, underrun_ev, run_entry;
    logic [16:0]            count_x, nsamps_x;

    assign count_x     = 17'(count_q);
    assign nsamps_x    = 17'(nsamps_q);
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign tick        = (state_q == RUN) && (div_q == '0);
    assign wr_ok       = wr_samp_A && !flush_A && !full;
    assign pop         = tick && !empty && !flush_A;
    assign underrun_ev = tick && empty && !flush_A;
    assign run_entry   = !flush_A && (state_q == PRIME) && (count_x >= nsamps_x);

    always_comb begin
        state_d = state_q;
        if (flush_A) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_A)     state_d = PRIME;
                PRIME:   if (run_entry)   state_d = RUN;
                RUN:     if (underrun_ev) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        nsamps_d   = nsamps_q;
        decim_d    = decim_q;
        div_d      = div_q;
        strobe_d   = 1'b0;
        zero_d     = zero_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        if (flush_A) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            div_d      = '0;
            zero_d     = 1'b1;
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (set_nsamps_A)
                nsamps_d = (freeze_tos_A[15:0] == '0) ? 16'd1 : freeze_tos_A[15:0];
            if (set_decim_A)
                decim_d = freeze_tos_A[15:0];
            if (wr_ok)
                wptr_d = wptr_q + 1'b1;
            if (wr_samp_A && full)
                overflow_d = 1'b1;
            if (pop) begin
                rptr_d   = rptr_q + 1'b1;
                zero_d   = 1'b0;
                strobe_d = 1'b1;
            end
            if (underrun_ev) begin
                zero_d     = 1'b1;
                strobe_d   = 1'b1;
                underrun_d = 1'b1;
            end
            count_d = count_q + CW'(wr_ok) - CW'(pop);
            if (run_entry)
                div_d = '0;
            else if (state_q == RUN)
                div_d = tick ? decim_q : div_q - 1'b1;
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            nsamps_q   <= 16'd1;
            decim_q    <= '0;
            div_q      <= '0;
            strobe_q   <= 1'b0;
            zero_q     <= 1'b1;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            nsamps_q   <= nsamps_d;
            decim_q    <= decim_d;
            div_q      <= div_d;
            strobe_q   <= strobe_d;
            zero_q     <= zero_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM read register has no reset; zero_q forces the output to 0 after reset, flush or underrun
    always_ff @(posedge adc_clk) begin
        if (wr_ok)
            mem_q[wptr_q] <= freeze_tos_A[15:0];
        if (pop)
            rd_q <= mem_q[rptr_q];
    end

    assign tx_dout_A   = zero_q ? '0 : rd_q;
    assign tx_strobe_A = strobe_q;
    assign srq_A       = (state_q != IDLE) && (count_x < nsamps_x);
    assign count_A     = count_q;
    assign underrun_A  = underrun_q;
    assign overflow_A  = overflow_q;

`ifdef TX_TICKS_EN
    logic [47:0] tx_ticks_q;
    logic        unused_bits;

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n)
            tx_ticks_q <= '0;
        else if (run_entry)
            tx_ticks_q <= ticks_A;
    end

    assign tx_ticks_A  = tx_ticks_q;
    assign unused_bits = ^freeze_tos_A[31:16];
`else
    logic unused_bits;

    assign tx_ticks_A  = '0;
    assign unused_bits = ^{freeze_tos_A[31:16], ticks_A};
`endif

endmodule

// File: tb/tb_tx_audio_fifo_wb.sv
// Directed self-checking bench for tx_audio_fifo_wb at DEPTH_LOG2=3.
module tb_tx_audio_fifo_wb;

    localparam int DL2 = 3;

    logic          adc_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   freeze_tos_A = '0;
    logic          wr_samp_A = 1'b0;
    logic          set_nsamps_A = 1'b0;
    logic          set_decim_A = 1'b0;
    logic          start_A = 1'b0;
    logic          flush_A = 1'b0;
    logic [47:0]   ticks_A = 48'h0000_0000_ABCD;
    logic [15:0]   tx_dout_A;
    logic          tx_strobe_A;
    logic          srq_A;
    logic [DL2:0]  count_A;
    logic          underrun_A;
    logic          overflow_A;
    logic [47:0]   tx_ticks_A;

    int errors = 0;
    int checks = 0;

    tx_audio_fifo_wb #(.DEPTH_LOG2(DL2)) dut (
        .adc_clk(adc_clk), .rst_n(rst_n), .freeze_tos_A(freeze_tos_A),
        .wr_samp_A(wr_samp_A), .set_nsamps_A(set_nsamps_A), .set_decim_A(set_decim_A),
        .start_A(start_A), .flush_A(flush_A), .ticks_A(ticks_A),
        .tx_dout_A(tx_dout_A), .tx_strobe_A(tx_strobe_A), .srq_A(srq_A),
        .count_A(count_A), .underrun_A(underrun_A), .overflow_A(overflow_A),
        .tx_ticks_A(tx_ticks_A)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic step();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        freeze_tos_A = {16'h0, v};
        wr_samp_A = 1'b1;
        step();
        wr_samp_A = 1'b0;
    endtask

    task automatic set_nsamps(input logic [15:0] v);
        freeze_tos_A = {16'h0, v};
        set_nsamps_A = 1'b1;
        step();
        set_nsamps_A = 1'b0;
    endtask

    task automatic set_decim(input logic [15:0] v);
        freeze_tos_A = {16'h0, v};
        set_decim_A = 1'b1;
        step();
        set_decim_A = 1'b0;
    endtask

    task automatic do_start();
        start_A = 1'b1;
        step();
        start_A = 1'b0;
    endtask

    task automatic do_flush();
        flush_A = 1'b1;
        step();
        flush_A = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (tx_dout_A !== 16'h0) begin errors++; $display("FAIL rst_dout: got %h want 0000", tx_dout_A); end
        checks++; if (tx_strobe_A !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", tx_strobe_A); end
        checks++; if (srq_A !== 1'b0) begin errors++; $display("FAIL rst_srq: got %b want 0", srq_A); end
        checks++; if (count_A !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count_A); end
        checks++; if ({underrun_A, overflow_A} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {underrun_A, overflow_A}); end
        checks++; if (tx_ticks_A !== 48'h0) begin errors++; $display("FAIL rst_ticks: got %h want 0", tx_ticks_A); end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if ({srq_A, tx_strobe_A, count_A} !== 6'b0) begin errors++; $display("FAIL rst_release: got %b want 000000", {srq_A, tx_strobe_A, count_A}); end
    endtask

    task automatic test_prime_pace();
        logic        exp_s;
        logic [15:0] exp_d;
        set_nsamps(16'd4);
        set_decim(16'd3);
        for (int i = 1; i <= 4; i++) push(16'(i));
        checks++; if (count_A !== 4'd4) begin errors++; $display("FAIL pace_count: got %0d want 4", count_A); end
        checks++; if (srq_A !== 1'b0) begin errors++; $display("FAIL pace_srq_idle: got %b want 0", srq_A); end
        do_start();
        for (int k = 1; k <= 18; k++) begin
            step();
            exp_s = (k >= 2) && (((k - 2) % 4) == 0);
            exp_d = (k == 18) ? 16'h0 : 16'((k - 2) / 4 + 1);
            checks++; if (tx_strobe_A !== exp_s) begin errors++; $display("FAIL pace_strobe k=%0d: got %b want %b", k, tx_strobe_A, exp_s); end
            if (exp_s) begin
                checks++; if (tx_dout_A !== exp_d) begin errors++; $display("FAIL pace_dout k=%0d: got %h want %h", k, tx_dout_A, exp_d); end
            end
            if (k == 1) begin
                checks++; if (srq_A !== 1'b0) begin errors++; $display("FAIL pace_srq_full: got %b want 0", srq_A); end
            end
            if (k == 2) begin
                checks++; if (srq_A !== 1'b1) begin errors++; $display("FAIL pace_srq_low: got %b want 1", srq_A); end
                checks++; if (underrun_A !== 1'b0) begin errors++; $display("FAIL pace_underrun_early: got %b want 0", underrun_A); end
            end
        end
    endtask

    task automatic test_underrun();
        logic        exp_s;
        logic [15:0] exp_d;
        checks++; if (underrun_A !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b want 1", underrun_A); end
        checks++; if (count_A !== 4'd0) begin errors++; $display("FAIL ur_count: got %0d want 0", count_A); end
        checks++; if (srq_A !== 1'b1) begin errors++; $display("FAIL ur_srq: got %b want 1", srq_A); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (tx_strobe_A !== 1'b0) begin errors++; $display("FAIL ur_prime_strobe k=%0d: got %b want 0", k, tx_strobe_A); end
        end
        for (int i = 5; i <= 8; i++) push(16'(i));
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_s = (k >= 2) && (((k - 2) % 4) == 0);
            exp_d = 16'((k - 2) / 4 + 5);
            checks++; if (tx_strobe_A !== exp_s) begin errors++; $display("FAIL ur_resume_strobe k=%0d: got %b want %b", k, tx_strobe_A, exp_s); end
            if (exp_s) begin
                checks++; if (tx_dout_A !== exp_d) begin errors++; $display("FAIL ur_resume_dout k=%0d: got %h want %h", k, tx_dout_A, exp_d); end
            end
        end
        checks++; if (underrun_A !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", underrun_A); end
    endtask

    task automatic test_overflow_wrap();
        logic [15:0] base;
        logic [15:0] exp_d;
        do_flush();
        set_decim(16'd0);
        for (int i = 0; i < 9; i++) push(16'h0010 + 16'(i));
        checks++; if (count_A !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", count_A); end
        checks++; if (overflow_A !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_A); end
        do_start();
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_d = (k == 10) ? 16'h0 : 16'h0010 + 16'(k - 2);
            checks++; if (tx_strobe_A !== (k >= 2)) begin errors++; $display("FAIL ovf_strobe k=%0d: got %b want %b", k, tx_strobe_A, (k >= 2)); end
            if (k >= 2) begin
                checks++; if (tx_dout_A !== exp_d) begin errors++; $display("FAIL ovf_dout k=%0d: got %h want %h", k, tx_dout_A, exp_d); end
            end
        end
        checks++; if ({underrun_A, count_A} !== 5'b1_0000) begin errors++; $display("FAIL ovf_drain: got %b want 10000", {underrun_A, count_A}); end
        set_nsamps(16'd6);
        for (int b = 0; b < 2; b++) begin
            base = (b == 0) ? 16'h0020 : 16'h0030;
            for (int i = 0; i < 6; i++) push(base + 16'(i));
            for (int k = 1; k <= 8; k++) begin
                step();
                exp_d = (k == 8) ? 16'h0 : base + 16'(k - 2);
                checks++; if (tx_strobe_A !== (k >= 2)) begin errors++; $display("FAIL wrap_strobe b=%0d k=%0d: got %b want %b", b, k, tx_strobe_A, (k >= 2)); end
                if (k >= 2) begin
                    checks++; if (tx_dout_A !== exp_d) begin errors++; $display("FAIL wrap_dout b=%0d k=%0d: got %h want %h", b, k, tx_dout_A, exp_d); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d;
        do_flush();
        checks++; if ({underrun_A, overflow_A} !== 2'b00) begin errors++; $display("FAIL b2b_flush_flags: got %b want 00", {underrun_A, overflow_A}); end
        set_decim(16'd0);
        set_nsamps(16'd4);
        for (int i = 0; i < 4; i++) push(16'h0040 + 16'(i));
        do_start();
        step();
        checks++; if (count_A !== 4'd4) begin errors++; $display("FAIL b2b_count0: got %0d want 4", count_A); end
        for (int i = 0; i < 8; i++) begin
            freeze_tos_A = {16'h0, 16'h0050 + 16'(i)};
            wr_samp_A = 1'b1;
            step();
            exp_d = (i < 4) ? 16'h0040 + 16'(i) : 16'h0050 + 16'(i - 4);
            checks++; if (count_A !== 4'd4) begin errors++; $display("FAIL b2b_count i=%0d: got %0d want 4", i, count_A); end
            checks++; if (tx_strobe_A !== 1'b1) begin errors++; $display("FAIL b2b_strobe i=%0d: got %b want 1", i, tx_strobe_A); end
            checks++; if (tx_dout_A !== exp_d) begin errors++; $display("FAIL b2b_dout i=%0d: got %h want %h", i, tx_dout_A, exp_d); end
        end
        wr_samp_A = 1'b0;
    endtask

    task automatic test_flush();
        logic        exp_s;
        logic [15:0] exp_d;
        for (int k = 0; k < 6; k++) step();
        checks++; if (underrun_A !== 1'b1) begin errors++; $display("FAIL fl_pre_underrun: got %b want 1", underrun_A); end
        set_decim(16'd2);
        set_nsamps(16'd2);
        freeze_tos_A = 32'h0000_DEAD;
        wr_samp_A = 1'b1;
        do_flush();
        wr_samp_A = 1'b0;
        checks++; if (count_A !== 4'd0) begin errors++; $display("FAIL fl_count: got %0d want 0", count_A); end
        checks++; if ({underrun_A, overflow_A, srq_A, tx_strobe_A} !== 4'b0) begin errors++; $display("FAIL fl_flags: got %b want 0000", {underrun_A, overflow_A, srq_A, tx_strobe_A}); end
        checks++; if (tx_dout_A !== 16'h0) begin errors++; $display("FAIL fl_dout: got %h want 0000", tx_dout_A); end
        push(16'h0060);
        do_start();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if ({srq_A, tx_strobe_A} !== 2'b10) begin errors++; $display("FAIL fl_nsamps_kept k=%0d: got %b want 10", k, {srq_A, tx_strobe_A}); end
        end
        push(16'h0061);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_s = (k == 2) || (k == 5) || (k == 8);
            exp_d = (k == 2) ? 16'h0060 : (k == 5) ? 16'h0061 : 16'h0;
            checks++; if (tx_strobe_A !== exp_s) begin errors++; $display("FAIL fl_decim_kept k=%0d: got %b want %b", k, tx_strobe_A, exp_s); end
            if (exp_s) begin
                checks++; if (tx_dout_A !== exp_d) begin errors++; $display("FAIL fl_dout k=%0d: got %h want %h", k, tx_dout_A, exp_d); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        push(16'h0070);
        push(16'h0071);
        step();
        step();
        checks++; if ({tx_strobe_A, tx_dout_A} !== {1'b1, 16'h0070}) begin errors++; $display("FAIL mr_pre: got %b/%h want 1/0070", tx_strobe_A, tx_dout_A); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({tx_dout_A, tx_strobe_A, srq_A} !== 18'h0) begin errors++; $display("FAIL mr_outs: got %h/%b/%b want 0/0/0", tx_dout_A, tx_strobe_A, srq_A); end
        checks++; if ({count_A, underrun_A, overflow_A} !== 6'b0) begin errors++; $display("FAIL mr_state: got %b want 000000", {count_A, underrun_A, overflow_A}); end
        checks++; if (tx_ticks_A !== 48'h0) begin errors++; $display("FAIL mr_ticks: got %h want 0", tx_ticks_A); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if ({tx_strobe_A, count_A} !== 5'b0) begin errors++; $display("FAIL mr_held k=%0d: got %b want 00000", k, {tx_strobe_A, count_A}); end
        end
        rst_n = 1'b1;
        step();
        checks++; if ({srq_A, tx_strobe_A, count_A} !== 6'b0) begin errors++; $display("FAIL mr_release: got %b want 000000", {srq_A, tx_strobe_A, count_A}); end
    endtask

    task automatic test_tx_ticks();
        logic [47:0] exp_t;
`ifdef TX_TICKS_EN
        exp_t = 48'h1234_5678_9ABC;
`else
        exp_t = 48'h0;
`endif
        push(16'h0077);
        ticks_A = 48'h0;
        do_start();
        ticks_A = 48'h1234_5678_9ABC;
        step();
        ticks_A = 48'h0000_0000_0001;
        checks++; if (tx_ticks_A !== exp_t) begin errors++; $display("FAIL ticks_latch: got %h want %h", tx_ticks_A, exp_t); end
        step();
        checks++; if ({tx_strobe_A, tx_dout_A} !== {1'b1, 16'h0077}) begin errors++; $display("FAIL ticks_sample: got %b/%h want 1/0077", tx_strobe_A, tx_dout_A); end
        checks++; if (tx_ticks_A !== exp_t) begin errors++; $display("FAIL ticks_hold: got %h want %h", tx_ticks_A, exp_t); end
    endtask

    initial begin
        test_reset();
        test_prime_pace();
        test_underrun();
        test_overflow_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_tx_ticks();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_audio_fifo_wb.md
# tx_audio_fifo_wb

Transmit-side audio sample buffer for the ecpu-to-DAC path. The ecpu pushes 16-bit samples, already synchronized into the adc_clk domain, into an on-chip FIFO. The block releases them at a programmed rate to the transmit datapath and raises a service request when the buffer runs low. It uses the same command and service-request structure as the rx audio path, in the opposite direction.

## Interface
- DEPTH_LOG2, 11: FIFO depth is 2^DEPTH_LOG2 samples.
- adc_clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- freeze_tos_A  in  32  frozen ecpu TOS; the command data bus.
- wr_samp_A  in  1  pulse; push freeze_tos_A[15:0] into the FIFO.
- set_nsamps_A  in  1  pulse; nsamps <= freeze_tos_A[15:0]. Value 0 is treated as 1.
- set_decim_A  in  1  pulse; decim <= freeze_tos_A[15:0].
- start_A  in  1  pulse; IDLE -> PRIME.
- flush_A  in  1  pulse; synchronous flush, see Operation.
- ticks_A  in  48  free-running tick counter.
- tx_dout_A  out  16  signed output sample, registered.
- tx_strobe_A  out  1  one-cycle pulse when tx_dout_A updates.
- srq_A  out  1  service request level.
- count_A  out  DEPTH_LOG2+1  FIFO occupancy.
- underrun_A  out  1  sticky underrun flag.
- overflow_A  out  1  sticky overflow flag.
- tx_ticks_A  out  48  ticks_A latched at RUN entry.

## Operation
- States:
  - IDLE: FIFO accepts writes; no reads.
  - PRIME: waits for count_A >= nsamps.
  - RUN: outputs samples.
- Transitions:
  - IDLE -> PRIME on start_A. start_A is ignored outside IDLE.
  - PRIME -> RUN when count_A >= nsamps.
  - RUN -> PRIME on underrun.
  - Any state -> IDLE on flush_A.
- Rate divider, 16 bits:
  - Loaded with 0 on PRIME->RUN, so the first tick falls on the first RUN cycle.
  - In RUN, a tick fires when the divider is 0; the divider then reloads with decim, otherwise it decrements.
  - Sample period is decim+1 cycles; decim=0 gives one sample per clock.
- Tick with count_A > 0: pop one sample to tx_dout_A.
- Tick with count_A == 0 (underrun):
  - tx_dout_A <= 0 and tx_strobe_A still pulses.
  - underrun_A is set.
  - State goes to PRIME.
- Write with count_A == 2^DEPTH_LOG2: the sample is dropped, overflow_A is set, and count_A is unchanged.
- A write and a pop in the same cycle leave count_A unchanged. Both the write and read pointers advance.
- Pointers are DEPTH_LOG2 bits and wrap modulo the depth. count_A is tracked separately at DEPTH_LOG2+1 bits.
- srq_A = (state != IDLE) && (count_A < nsamps). It is combinational from registered state and count.
- flush_A clears the following and forces IDLE:
  - pointers and count_A
  - underrun_A and overflow_A
  - the divider
  - tx_dout_A (to 0)
  - nsamps and decim are kept.
- flush_A has priority over all other commands in the same cycle. Writes coinciding with flush_A are discarded.
- Reset values:
  - state IDLE
  - tx_dout_A 0, tx_strobe_A 0, srq_A 0
  - count_A 0, underrun_A 0, overflow_A 0
  - tx_ticks_A 0
  - nsamps 1, decim 0
- Reset mid-RUN aborts immediately, with no output strobe.

## Timing
- Write at cycle N: count_A increments at N+1. The sample is poppable from N+1.
- Tick at cycle N: tx_dout_A and tx_strobe_A are valid at N+1. This is one cycle of synchronous RAM read latency.
- PRIME->RUN is evaluated at cycle N from the registered count_A. The first tick is at N+1 and the first strobe at N+2.
- Command pulses are single-cycle. Data is sampled from freeze_tos_A in the same cycle as the pulse.

## Configuration
- TX_TICKS_EN defined: tx_ticks_A <= ticks_A on every PRIME->RUN transition, giving a timestamp for each burst start.
- TX_TICKS_EN undefined: tx_ticks_A is tied to 0 and the latch register is not built.
- The port list is identical in both builds.

## Test plan
- Prime and pace:
  - Stimulus: nsamps=4, decim=3, write 1,2,3,4, then start_A.
  - Required: strobes 4 cycles apart carrying 1,2,3,4; srq_A asserts once count_A < 4.
- Underrun:
  - Stimulus: continue the prime-and-pace case with no further writes.
  - Required: the 5th strobe outputs 0, underrun_A=1, state PRIME. Writing 4 more samples resumes RUN.
- Overflow and wrap:
  - Stimulus: DEPTH_LOG2=3, write 9 samples in IDLE.
  - Required: count_A=8, overflow_A=1, 9th sample dropped. Play out, then refill past pointer wrap with no data corruption.
- Simultaneous write and pop:
  - Stimulus: decim=0, write every cycle while RUN.
  - Required: count_A constant; output order equals input order.
- Flush and reset mid-RUN:
  - flush_A: IDLE, count_A=0, flags 0, nsamps/decim retained.
  - rst_n low async: all outputs 0 immediately.
- TX_TICKS_EN:
  - Stimulus: ticks_A=0x123456789ABC at the PRIME->RUN cycle.
  - Required: tx_ticks_A=0x123456789ABC when defined, 0 when undefined.
